// File: rtl/pulse_sequencer_pkg.sv
// pulse_sequencer_pkg: command codes and FSM state encoding shared by the pulse sequencer
package pulse_sequencer_pkg;
  localparam logic [7:0] SEQ_SLOT_SEL = 8'h20;
  localparam logic [7:0] SEQ_DELAY    = 8'h21;
  localparam logic [7:0] SEQ_WIDTH    = 8'h22;
  localparam logic [7:0] SEQ_NUM      = 8'h23;
  localparam logic [7:0] SEQ_ARM      = 8'h24;
  localparam logic [7:0] SEQ_STATUS   = 8'h25;
  typedef enum logic [1:0] {
    SEQ_ST_IDLE      = 2'd0,
    SEQ_ST_WAIT_TRIG = 2'd1,
    SEQ_ST_DELAY     = 2'd2,
    SEQ_ST_PULSE     = 2'd3
  } seq_state_e;
endpackage

// File: rtl/seq_slot_regs.sv
// seq_slot_regs: per-slot delay/width register file plus slot select and slot count
module seq_slot_regs
  import pulse_sequencer_pkg::*;
#(
  parameter int N_SLOTS = 4,
  parameter int CNT_W   = 24
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [7:0]                      cmd_i,
  input  logic [15:0]                     bytecount_i,
  input  logic [7:0]                      wdata_i,
  input  logic                            write_i,
  input  logic                            busy_i,
  output logic [7:0]                      rdata_o,
  output logic [N_SLOTS-1:0][CNT_W-1:0]   delay_o,
  output logic [N_SLOTS-1:0][CNT_W-1:0]   width_o,
  output logic [4:0]                      num_eff_o
);
  localparam int SEL_W = N_SLOTS > 1 ? $clog2(N_SLOTS) : 1;
  localparam logic [7:0] N8 = 8'(N_SLOTS);
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_SLOTS-1:0][CNT_W-1:0] delay_q, delay_d, width_q, width_d;
  logic [7:0] num_q, num_d;
  logic byte_ok, wr_en, first;
  logic [CNT_W-1:0] rd_word, rd_shift;

  function automatic logic [CNT_W-1:0] put_byte(logic [CNT_W-1:0] v, logic [1:0] b, logic [7:0] d);
    for (int i = 0; i < CNT_W; i++)
      if (i / 8 == int'(b)) v[i] = d[3'(i % 8)];
    return v;
  endfunction

  assign byte_ok = bytecount_i < 16'd3;
  assign first   = bytecount_i == 16'd0;
  assign wr_en   = write_i & byte_ok & ~busy_i;

  always_comb begin
    sel_d   = sel_q;
    delay_d = delay_q;
    width_d = width_q;
    num_d   = num_q;
    if (wr_en && first && cmd_i == SEQ_SLOT_SEL) sel_d = SEL_W'(wdata_i % N8);
    if (wr_en && cmd_i == SEQ_DELAY) delay_d[sel_q] = put_byte(delay_q[sel_q], bytecount_i[1:0], wdata_i);
    if (wr_en && cmd_i == SEQ_WIDTH) width_d[sel_q] = put_byte(width_q[sel_q], bytecount_i[1:0], wdata_i);
    if (wr_en && first && cmd_i == SEQ_NUM) num_d = wdata_i > N8 ? N8 : wdata_i;
  end

  assign rd_word  = cmd_i == SEQ_DELAY ? delay_q[sel_q] : width_q[sel_q];
  assign rd_shift = rd_word >> {bytecount_i[1:0], 3'b000};
  assign rdata_o  = !byte_ok ? 8'h00 :
                    (cmd_i == SEQ_DELAY || cmd_i == SEQ_WIDTH) ? rd_shift[7:0] :
                    (cmd_i == SEQ_NUM && first) ? num_q :
                    (cmd_i == SEQ_SLOT_SEL && first) ? 8'(sel_q) : 8'h00;
  // A stored count of zero still plays one slot
  assign num_eff_o = num_q == 8'd0 ? 5'd1 : num_q[4:0];
  assign delay_o   = delay_q;
  assign width_o   = width_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q   <= '0;
      delay_q <= '0;
      width_q <= '0;
      num_q   <= 8'd1;
    end else begin
      sel_q   <= sel_d;
      delay_q <= delay_d;
      width_q <= width_d;
      num_q   <= num_d;
    end
  end
endmodule

// File: rtl/pulse_sequencer.sv
// pulse_sequencer: armed one-shot player of programmed (delay, width) pulse pairs on trigger_out
module pulse_sequencer
  import pulse_sequencer_pkg::*;
#(
  parameter int N_SLOTS = 4,
  parameter int CNT_W   = 24
) (
  input  logic        timerclk,
  input  logic        reset,
  input  logic        trigger_in,
  input  logic [7:0]  reg_cmd,
  input  logic [15:0] reg_bytecount,
  input  logic [7:0]  reg_data_in,
  output logic [7:0]  reg_data_out,
  input  logic        reg_read,
  input  logic        reg_write,
  output logic        trigger_out,
  output logic        busy,
  output logic        done
);
  localparam int SEL_W = N_SLOTS > 1 ? $clog2(N_SLOTS) : 1;
  seq_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] slot_q, slot_d, slot_nx;
  logic trig_prev_q, done_q, done_d, out_q;
  logic arm_wr, arm, abort, trig_edge, last;
  logic [N_SLOTS-1:0][CNT_W-1:0] delay, width;
  logic [4:0] num_eff;
  logic [7:0] cfg_rdata, status;

  function automatic logic [CNT_W-1:0] at_least1(logic [CNT_W-1:0] v);
    return v == '0 ? CNT_W'(1) : v;
  endfunction

  seq_slot_regs #(.N_SLOTS(N_SLOTS), .CNT_W(CNT_W)) u_regs (
    .clk_i       (timerclk),
    .rst_i       (reset),
    .cmd_i       (reg_cmd),
    .bytecount_i (reg_bytecount),
    .wdata_i     (reg_data_in),
    .write_i     (reg_write),
    .busy_i      (busy),
    .rdata_o     (cfg_rdata),
    .delay_o     (delay),
    .width_o     (width),
    .num_eff_o   (num_eff)
  );

  assign arm_wr    = reg_write && reg_cmd == SEQ_ARM && reg_bytecount == 16'd0;
  assign abort     = arm_wr & reg_data_in[1];
  assign arm       = arm_wr & reg_data_in[0] & ~reg_data_in[1];
  assign trig_edge = trigger_in & ~trig_prev_q;
  assign slot_nx   = slot_q + 4'd1;
  assign last      = {1'b0, slot_q} == num_eff - 5'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    done_d  = done_q;
    if (abort) state_d = SEQ_ST_IDLE;
    else case (state_q)
      SEQ_ST_IDLE: begin
        state_d = arm ? SEQ_ST_WAIT_TRIG : SEQ_ST_IDLE;
        done_d  = arm ? 1'b0 : done_q;
      end
      SEQ_ST_WAIT_TRIG: if (trig_edge) begin
        state_d = delay[0] == '0 ? SEQ_ST_PULSE : SEQ_ST_DELAY;
        cnt_d   = delay[0] == '0 ? at_least1(width[0]) - CNT_W'(1) : delay[0];
      end
      SEQ_ST_DELAY: begin
        state_d = cnt_q == CNT_W'(1) ? SEQ_ST_PULSE : SEQ_ST_DELAY;
        cnt_d   = cnt_q == CNT_W'(1) ? at_least1(width[SEL_W'(slot_q)]) - CNT_W'(1) : cnt_q - CNT_W'(1);
      end
      SEQ_ST_PULSE: begin
        // The gap before a later slot is forced to at least one cycle
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else if (last) begin
          state_d = SEQ_ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = SEQ_ST_DELAY;
          slot_d  = slot_nx;
          cnt_d   = at_least1(delay[SEL_W'(slot_nx)]);
        end
      end
      default: state_d = SEQ_ST_IDLE;
    endcase
    if (state_d == SEQ_ST_IDLE) slot_d = '0;
  end

  always_ff @(posedge timerclk) begin
    if (reset) begin
      state_q     <= SEQ_ST_IDLE;
      cnt_q       <= '0;
      slot_q      <= '0;
      trig_prev_q <= 1'b0;
      done_q      <= 1'b0;
      out_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      trig_prev_q <= trigger_in;
      done_q      <= done_d;
      out_q       <= state_d == SEQ_ST_PULSE;
    end
  end

  assign status       = {done_q, 2'b00, slot_q[2:0], state_q};
  assign reg_data_out = !reg_read ? 8'h00 :
                        reg_cmd == SEQ_STATUS ? (reg_bytecount == 16'd0 ? status : 8'h00) : cfg_rdata;
  assign trigger_out  = out_q;
  assign busy         = state_q != SEQ_ST_IDLE;
  assign done         = done_q;
endmodule

// File: tb/tb_pulse_sequencer.sv
// tb_pulse_sequencer: randomized scoreboard bench; a pulse-list model feeds a queue checked by a monitor
module tb_pulse_sequencer;
  import pulse_sequencer_pkg::*;
  localparam int N = 4;
  logic clk = 0, reset = 1, trigger_in = 0, reg_read = 0, reg_write = 0;
  logic [7:0] reg_cmd = 0, reg_data_in = 0, reg_data_out;
  logic [15:0] reg_bytecount = 0;
  logic trigger_out, busy, done;
  typedef struct {int start; int len;} pulse_t;
  pulse_t exp_q[$];
  int checks = 0, errors = 0, cyc = 0;
  int m_d[N], m_w[N], m_num;

  pulse_sequencer #(.N_SLOTS(N), .CNT_W(24)) dut (
    .timerclk(clk), .reset(reset), .trigger_in(trigger_in), .reg_cmd(reg_cmd),
    .reg_bytecount(reg_bytecount), .reg_data_in(reg_data_in), .reg_data_out(reg_data_out),
    .reg_read(reg_read), .reg_write(reg_write), .trigger_out(trigger_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitor: every pulse on trigger_out must match the head of the expected queue
  logic prev_out = 0;
  bit have = 0;
  int rise_c;
  pulse_t cur;
  always @(negedge clk) begin
    if (trigger_out === 1'b1 && !prev_out) begin
      rise_c = cyc;
      have = exp_q.size() > 0;
      if (!have) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse rising at cycle %0d with no pulse expected", cyc);
      end else begin
        cur = exp_q.pop_front();
        chk("pulse_start", cyc, cur.start);
      end
    end
    if (trigger_out !== 1'b1 && prev_out && have) chk("pulse_len", cyc - rise_c, cur.len);
    prev_out = trigger_out === 1'b1;
  end

  task automatic wr(logic [7:0] c, logic [15:0] b, logic [7:0] d);
    reg_cmd = c; reg_bytecount = b; reg_data_in = d; reg_write = 1;
    @(posedge clk); #1;
    reg_write = 0;
  endtask

  task automatic rd_chk(string nm, logic [7:0] c, logic [15:0] b, logic [7:0] exp);
    reg_cmd = c; reg_bytecount = b; reg_read = 1;
    #1 chk(nm, reg_data_out, exp);
    reg_read = 0;
  endtask

  task automatic set_slot(int s, int d, int w);
    wr(SEQ_SLOT_SEL, 0, 8'(s));
    for (int b = 0; b < 3; b++) wr(SEQ_DELAY, 16'(b), 8'(d >> (8 * b)));
    for (int b = 0; b < 3; b++) wr(SEQ_WIDTH, 16'(b), 8'(w >> (8 * b)));
    m_d[s] = d; m_w[s] = w;
  endtask

  task automatic set_num(int n);
    wr(SEQ_NUM, 0, 8'(n));
    m_num = n > N ? N : n;
  endtask

  // Model: expected pulse train derived from the programmed slots
  task automatic play(bit do_arm);
    int t, st, e, ne, w;
    if (do_arm) wr(SEQ_ARM, 0, 8'h01);
    @(posedge clk); #1;
    t = cyc;
    ne = m_num == 0 ? 1 : m_num;
    st = t + 1 + m_d[0];
    e = st;
    for (int k = 0; k < ne; k++) begin
      w = m_w[k] < 1 ? 1 : m_w[k];
      exp_q.push_back('{start: st, len: w});
      e = st + w;
      if (k < ne - 1) st = e + (m_d[k+1] < 1 ? 1 : m_d[k+1]);
    end
    trigger_in = 1;
    @(posedge clk); #1;
    trigger_in = 0;
    @(negedge clk);
    while (cyc < e) @(negedge clk);
    #1;
    chk("done_at_end", done, 1);
    chk("busy_at_end", busy, 0);
    chk("out_at_end", trigger_out, 0);
    chk("queue_empty", exp_q.size(), 0);
    rd_chk("status_done", SEQ_STATUS, 0, 8'h80);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t, s;
    for (int i = 0; i < N; i++) begin m_d[i] = 0; m_w[i] = 0; end
    m_num = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("rst_out", trigger_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rd_chk("rst_status", SEQ_STATUS, 0, 8'h00);
    rd_chk("rst_num", SEQ_NUM, 0, 8'd1);
    rd_chk("rst_delay", SEQ_DELAY, 0, 8'h00);
    rd_chk("unknown_cmd", 8'h55, 0, 8'h00);
    reg_cmd = SEQ_NUM; reg_bytecount = 0; reg_read = 0;
    #1 chk("read_gated", reg_data_out, 0);
    // Full-range values, byte ordering, out-of-range byte index, slot select modulo
    set_slot(1, 24'hFFFFFF, 24'hABCDEF);
    rd_chk("max_delay_b2", SEQ_DELAY, 2, 8'hFF);
    rd_chk("width_b0", SEQ_WIDTH, 0, 8'hEF);
    rd_chk("width_b1", SEQ_WIDTH, 1, 8'hCD);
    rd_chk("width_b3_zero", SEQ_WIDTH, 3, 8'h00);
    wr(SEQ_DELAY, 3, 8'h00);
    rd_chk("ignored_b3_write", SEQ_DELAY, 0, 8'hFF);
    wr(SEQ_SLOT_SEL, 0, 8'd5);
    rd_chk("sel_modulo", SEQ_WIDTH, 2, 8'hAB);
    set_slot(1, 0, 0);
    // Single slot
    set_slot(0, 5, 3); set_num(1); play(1);
    // Three slots with zero delays
    set_slot(0, 0, 2); set_slot(1, 3, 1); set_slot(2, 0, 4); set_num(3); play(1);
    // Zero width and count clamps
    set_slot(0, 2, 0); set_num(1); play(1);
    set_slot(3, 1, 1); set_num(9);
    rd_chk("num_clamp", SEQ_NUM, 0, 8'd4);
    play(1);
    set_num(0);
    rd_chk("num_zero", SEQ_NUM, 0, 8'd0);
    play(1);
    // Abort during a long delay; a later edge must not fire
    set_slot(0, 1000, 2); set_num(1);
    wr(SEQ_ARM, 0, 8'h01);
    trigger_in = 1; @(posedge clk); #1; trigger_in = 0;
    repeat (9) @(posedge clk);
    #1 wr(SEQ_ARM, 0, 8'h02);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    rd_chk("abort_status", SEQ_STATUS, 0, 8'h00);
    repeat (1100) @(posedge clk);
    #1 trigger_in = 1; @(posedge clk); #1; trigger_in = 0;
    repeat (20) @(posedge clk);
    #1 chk("unarmed_busy", busy, 0);
    // Config lock while waiting for the trigger
    wr(SEQ_ARM, 0, 8'h01);
    chk("armed_busy", busy, 1);
    wr(SEQ_SLOT_SEL, 0, 8'd3);
    wr(SEQ_DELAY, 0, 8'd77);
    wr(SEQ_NUM, 0, 8'd2);
    rd_chk("locked_delay", SEQ_DELAY, 0, 8'(m_d[0]));
    rd_chk("locked_num", SEQ_NUM, 0, 8'(m_num));
    wr(SEQ_ARM, 0, 8'h02);
    // Trigger already high when arming: needs a fresh rising edge
    set_slot(0, 3, 2);
    trigger_in = 1;
    wr(SEQ_ARM, 0, 8'h01);
    repeat (10) @(posedge clk);
    #1 chk("level_no_fire", busy, 1);
    trigger_in = 0;
    @(posedge clk); #1;
    play(0);
    // Randomized programs
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < N; k++) set_slot(k, int'($urandom_range(0, 12)), int'($urandom_range(0, 6)));
      set_num(int'($urandom_range(0, 9)));
      s = int'($urandom_range(0, N - 1));
      wr(SEQ_SLOT_SEL, 0, 8'(s));
      rd_chk("rand_width_rb", SEQ_WIDTH, 0, 8'(m_w[s]));
      play(1);
    end
    // Reset in the middle of a long pulse
    set_slot(0, 0, 100); set_num(1);
    wr(SEQ_ARM, 0, 8'h01);
    @(posedge clk); #1;
    t = cyc;
    exp_q.push_back('{start: t + 1, len: 6});
    trigger_in = 1; @(posedge clk); #1; trigger_in = 0;
    repeat (5) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("rst_mid_out", trigger_out, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    rd_chk("rst_mid_status", SEQ_STATUS, 0, 8'h00);
    rd_chk("rst_mid_num", SEQ_NUM, 0, 8'd1);
    rd_chk("rst_mid_width", SEQ_WIDTH, 0, 8'h00);
    repeat (3) @(posedge clk);
    #1 chk("rst_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
- Trigger-driven glitch scheduler that plays back up to N_SLOTS programmed (delay, width) pulse pairs on trigger_out after a single armed rising edge of trigger_in.
- Sits between the external trigger input and the glitch output.
- Configured and armed through the standard serial register interface (reg_cmd / reg_bytecount / reg_data_*).
- One-shot: disarms itself after the last slot.

Parameters:
- N_SLOTS, 4, number of programmable (delay, width) slots; 1..16.
- CNT_W, 24, width of the delay, width and counter registers; 3 register bytes.

Ports:
- timerclk  in  1  sole clock; the register interface is synchronous to it.
- reset  in  1  synchronous, active-high reset.
- trigger_in  in  1  external trigger, already synchronised to timerclk.
- reg_cmd  in  8  command code.
- reg_bytecount  in  16  byte index within the command.
- reg_data_in  in  8  write data.
- reg_data_out  out  8  read data; combinational.
- reg_read  in  1  read strobe.
- reg_write  in  1  write strobe.
- trigger_out  out  1  registered glitch output.
- busy  out  1  high in any state except IDLE.
- done  out  1  sticky "sequence completed".

Behaviour:
- Commands, defined in commands.v:
  - SEQ_SLOT_SEL=0x20: 1 byte, selected slot = data mod N_SLOTS.
  - SEQ_DELAY=0x21: bytes 0..2, little-endian, selected slot delay.
  - SEQ_WIDTH=0x22: bytes 0..2, little-endian, selected slot width.
  - SEQ_NUM=0x23: 1 byte, slot count.
  - SEQ_ARM=0x24: write only; bit0 arm, bit1 abort.
  - SEQ_STATUS=0x25: read only; byte0 = {done, 2'b0, slot_idx[2:0], state[1:0]}.
- Register access rules:
  - bytecount > 2 is ignored on write and reads 0.
  - Reads of SEQ_DELAY, SEQ_WIDTH and SEQ_NUM return stored values.
  - Unknown commands read 0.
  - reg_data_out = 0 when reg_read is low.
- Config lock: writes to 0x20..0x23 are ignored while busy.
- Slot count: stored 0 is treated as 1; values > N_SLOTS are clamped to N_SLOTS on write.
- Reset:
  - trigger_out, busy and done = 0.
  - All delays and widths = 0; num = 1; slot_sel = 0.
  - FSM enters IDLE; trig_prev = 0.
- Edge detect: trig_prev is registered every cycle. The edge condition is trigger_in & ~trig_prev.
- FSM states (2-bit encoding): IDLE=0, WAIT_TRIG=1, DELAY=2, PULSE=3.
  - IDLE:
    - A write to SEQ_ARM with bit0=1 and bit1=0 moves to WAIT_TRIG and clears done.
    - slot_idx = 0.
  - WAIT_TRIG:
    - On edge at cycle T, load cnt = delay[0].
    - If delay[0] == 0, go straight to PULSE with cnt = max(width[0],1) - 1.
    - Otherwise go to DELAY.
  - DELAY:
    - cnt decrements each cycle.
    - When cnt == 1, next state is PULSE with cnt = max(width,1) - 1.
  - PULSE:
    - trigger_out = 1 for exactly max(width[slot_idx],1) cycles.
    - At cnt == 0, leave PULSE.
    - If slot_idx == num-1: go to IDLE, set done = 1, trigger_out = 0.
    - Otherwise slot_idx++ and go to DELAY with cnt = max(delay[slot_idx+1],1). The inter-pulse gap is never 0.
- Timing:
  - Slot 0: trigger_out rises at cycle T + 1 + delay[0].
  - Slot k > 0: the low gap equals max(delay[k],1) cycles.
- trigger_out is registered. It is high exactly when state == PULSE and is driven from a flop, not decoded combinationally.
- Abort:
  - SEQ_ARM write with bit1=1 in any state goes to IDLE next cycle.
  - trigger_out = 0 next cycle; done unchanged.
  - Abort has priority over arm and over the trigger edge in the same cycle.
- Ignored events:
  - Arm while busy.
  - trigger_in edges outside WAIT_TRIG.
  - trigger_in held high when arming does not fire; a fresh rising edge is required.
- reset mid-sequence behaves the same as power-up reset. trigger_out drops the next cycle.
- Delay and width values up to 2^CNT_W - 1 must work. The counter never wraps.

Decomposition:
- Shared: commands.v gains SEQ_* command codes and the state encoding constants (SEQ_ST_IDLE..SEQ_ST_PULSE).
- Sub-module seq_slot_regs: the N_SLOTS × 2 × CNT_W config register file with byte-write, read mux, clamp and lock logic.
- The FSM, counter and output flop stay in pulse_sequencer.

Test Plan:
- Single slot: num=1, delay0=5, width0=3, arm, edge at T → trigger_out high T+6..T+8, done=1 at T+9, busy=0.
- Three slots: widths 2,1,4 and delays 0,3,0, edge at T → high T+1..T+2; low 3 cycles; high 1 cycle; low 1 cycle (gap clamped); high 4 cycles; done=1.
- Zero-width and count clamps: width0=0 → 1-cycle pulse. SEQ_NUM write 9 with N_SLOTS=4 reads back 4. SEQ_NUM write 0 plays 1 slot.
- Abort: delay0=1000, edge, abort at T+10 → state IDLE at T+11, no pulse, done stays 0. A later edge is ignored until re-armed.
- Lock and level: SEQ_DELAY write while WAIT_TRIG is ignored (readback unchanged). Arm with trigger_in already high → no fire until low→high.
- Reset during PULSE with width=100 → trigger_out 0 next cycle, all regs at reset values, STATUS reads 0x00.
